// File: rtl/gcd_pkg.sv
// Shared definitions for the two-client GCD core arbiter: FSM state encoding
// and default operand/result widths.
package gcd_pkg;

  localparam int OPW_DEF = 8;
  localparam int RW_DEF  = 7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RELEASE = 2'd2,
    RESPOND = 2'd3
  } state_e;

endpackage

// File: rtl/gcd_arbiter_rr_arb2.sv
// Two-way round-robin grant: combinational pick from the current requests,
// with a registered last-granted pointer that the owner updates on completion.
module rr_arb2
  import gcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       upd_idx,
  output logic       gnt_idx,
  output logic       gnt_any
);

  logic last_q, last_d;

  always_comb begin
    last_d = last_q;
    if (upd) last_d = upd_idx;
  end

  // Pointer starts at client 1 so client 0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_q <= 1'b1;
    else       last_q <= last_d;
  end

  always_comb begin
    gnt_any = |req;
    if (&req) gnt_idx = ~last_q;
    else      gnt_idx = req[1];
  end

endmodule

// File: rtl/gcd_arbiter.sv
// Shares one 4-phase GCD core between two 4-phase clients; operands and the
// result are latched so every output comes straight from a flop.
module gcd_arbiter
  import gcd_pkg::*;
#(
  parameter int OPW = OPW_DEF,
  parameter int RW  = RW_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [2*OPW-1:0] ab0,
  input  logic [2*OPW-1:0] ab1,
  output logic             ack0,
  output logic             ack1,
  output logic [RW-1:0]    c_out,
  output logic             core_req,
  output logic [2*OPW-1:0] core_ab,
  input  logic             core_ack,
  input  logic [RW-1:0]    core_c,
  output logic             busy,
  output logic             grant
);

  state_e             state_q, state_d;
  logic               grant_q, grant_d;
  logic [2*OPW-1:0]   core_ab_q, core_ab_d;
  logic [RW-1:0]      c_out_q, c_out_d;
  logic               core_req_q, core_req_d;
  logic [1:0]         ack_q, ack_d;
  logic               busy_q, busy_d;

  logic [1:0]         req;
  logic               arb_idx, arb_any, arb_upd;

  assign req = {req1, req0};

  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .upd     (arb_upd),
    .upd_idx (grant_q),
    .gnt_idx (arb_idx),
    .gnt_any (arb_any)
  );

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    core_ab_d  = core_ab_q;
    c_out_d    = c_out_q;
    core_req_d = core_req_q;
    ack_d      = ack_q;
    arb_upd    = 1'b0;
    case (state_q)
      IDLE: begin
        // A core still acking a previous (possibly aborted) request blocks issue.
        if (arb_any && !core_ack) begin
          state_d    = ISSUE;
          grant_d    = arb_idx;
          core_ab_d  = arb_idx ? ab1 : ab0;
          core_req_d = 1'b1;
        end
      end
      ISSUE: begin
        if (core_ack) begin
          state_d    = RELEASE;
          c_out_d    = core_c;
          core_req_d = 1'b0;
        end
      end
      RELEASE: begin
        if (!core_ack) begin
          state_d = RESPOND;
          ack_d   = grant_q ? 2'b10 : 2'b01;
        end
      end
      RESPOND: begin
        if (!req[grant_q]) begin
          state_d = IDLE;
          ack_d   = 2'b00;
          arb_upd = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= 1'b0;
      core_ab_q  <= '0;
      c_out_q    <= '0;
      core_req_q <= 1'b0;
      ack_q      <= 2'b00;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      core_ab_q  <= core_ab_d;
      c_out_q    <= c_out_d;
      core_req_q <= core_req_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
    end
  end

  assign ack0     = ack_q[0];
  assign ack1     = ack_q[1];
  assign c_out    = c_out_q;
  assign core_req = core_req_q;
  assign core_ab  = core_ab_q;
  assign busy     = busy_q;
  assign grant    = grant_q;

endmodule

// File: tb/tb_gcd_arbiter.sv
// Bench for gcd_arbiter: behavioural GCD core (3-cycle ack), transaction-level
// reference model with a per-cycle compare process, directed and random clients.
module tb_gcd_arbiter;

  localparam int OPW = 8;
  localparam int RW  = 7;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0, req1;
  logic [2*OPW-1:0] ab0, ab1;
  logic             ack0, ack1;
  logic [RW-1:0]    c_out;
  logic             core_req;
  logic [2*OPW-1:0] core_ab;
  logic             core_ack = 1'b0;
  logic [RW-1:0]    core_c = '0;
  logic             busy, grant;

  int checks = 0;
  int errors = 0;

  gcd_arbiter #(.OPW(OPW), .RW(RW)) dut (
    .clk      (clk),
    .reset    (reset),
    .req0     (req0),
    .req1     (req1),
    .ab0      (ab0),
    .ab1      (ab1),
    .ack0     (ack0),
    .ack1     (ack1),
    .c_out    (c_out),
    .core_req (core_req),
    .core_ab  (core_ab),
    .core_ack (core_ack),
    .core_c   (core_c),
    .busy     (busy),
    .grant    (grant)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] gcd_rw(input logic [2*OPW-1:0] ab);
    int unsigned a, b, t;
    a = int'(ab[2*OPW-1:OPW]);
    b = int'(ab[OPW-1:0]);
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return RW'(a);
  endfunction

  // Behavioural core: 4-phase, ack three cycles after core_req rises.
  int core_mode = 0;  // 0 normal, 1 never acks, 2 ack forced high
  int ccnt = 0;
  always @(posedge clk) begin
    case (core_mode)
      1: core_ack <= 1'b0;
      2: core_ack <= 1'b1;
      default: begin
        if (core_req && !core_ack) begin
          if (ccnt == 2) begin
            core_ack <= 1'b1;
            core_c   <= gcd_rw(core_ab);
            ccnt     <= 0;
          end else begin
            ccnt <= ccnt + 1;
          end
        end else begin
          ccnt <= 0;
          if (!core_req && core_ack) core_ack <= 1'b0;
        end
      end
    endcase
  end

  // Reference model: inputs seen at each active edge, transaction ownership.
  logic [1:0]       req_s;
  logic [2*OPW-1:0] ab_s [2];
  always @(posedge clk) begin
    req_s   <= {req1, req0};
    ab_s[0] <= ab0;
    ab_s[1] <= ab1;
  end

  int               last_m = 1;
  int               cur = 0;
  int               expg;
  bit               in_txn = 0, prev_cr = 0, prev_ack = 0;
  logic [2*OPW-1:0] cur_ab = '0;

  always @(negedge clk) begin
    if (reset) begin
      last_m   = 1;
      in_txn   = 0;
      prev_cr  = 0;
      prev_ack = 0;
    end else begin
      if (prev_ack && !(ack0 || ack1)) begin
        last_m = cur;
        in_txn = 0;
      end
      if (core_req && !prev_cr) begin
        if (req_s == 2'b11) expg = 1 - last_m;
        else                expg = req_s[1] ? 1 : 0;
        chk("grant_had_request", 32'(req_s != 2'b00), 1);
        chk("grant_pick", 32'(grant), expg);
        chk("core_ab_pick", 32'(core_ab), 32'(ab_s[expg]));
        cur    = expg;
        cur_ab = ab_s[expg];
        in_txn = 1;
      end
      if (core_req) chk("core_req_in_txn", 32'(in_txn), 1);
      chk("busy_track", 32'(busy), 32'(in_txn));
      if (ack0 || ack1) begin
        chk("ack_onehot", 32'(ack0 && ack1), 0);
        chk("ack_owner", 32'(ack1), cur);
        chk("ack_grant", 32'(grant), cur);
        chk("ack_c_out", 32'(c_out), 32'(gcd_rw(cur_ab)));
        chk("ack_in_txn", 32'(in_txn), 1);
      end
      prev_cr  = core_req;
      prev_ack = ack0 || ack1;
    end
  end

  task automatic wait_ack(input int idx, input string nm);
    int n = 0;
    while (n < 60) begin
      @(negedge clk);
      if ((idx == 0 && ack0) || (idx == 1 && ack1)) break;
      n++;
    end
    chk({nm, "_ack_seen"}, 32'(n < 60), 1);
  endtask

  task automatic wait_any(input string nm);
    int n = 0;
    while (n < 60) begin
      @(negedge clk);
      if (ack0 || ack1) break;
      n++;
    end
    chk({nm, "_ack_seen"}, 32'(n < 60), 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req0  = 1'b0;
    req1  = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ack0"}, 32'(ack0), 0);
    chk({nm, "_ack1"}, 32'(ack1), 0);
    chk({nm, "_core_req"}, 32'(core_req), 0);
    chk({nm, "_busy"}, 32'(busy), 0);
    chk({nm, "_grant"}, 32'(grant), 0);
    chk({nm, "_c_out"}, 32'(c_out), 0);
    chk({nm, "_core_ab"}, 32'(core_ab), 0);
  endtask

  bit raise_en;
  int n;

  initial begin
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; ab0 = '0; ab1 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;

    // Single client
    @(posedge clk); #1 req0 = 1'b1; ab0 = {8'd48, 8'd18};
    wait_ack(0, "single");
    chk("single_core_ab", 32'(core_ab), 32'h3012);
    chk("single_c_out", 32'(c_out), 6);
    chk("single_grant", 32'(grant), 0);
    @(posedge clk); #1 req0 = 1'b0;
    chk("single_ack_held", 32'(ack0), 1);
    @(posedge clk); #1;
    chk("single_ack_fall", 32'(ack0), 0);
    chk("single_idle", 32'(busy), 0);

    // Tie after reset: client 0 first
    do_reset();
    @(posedge clk); #1
    req0 = 1'b1; req1 = 1'b1; ab0 = {8'd12, 8'd8}; ab1 = {8'd35, 8'd21};
    wait_ack(0, "tie0");
    chk("tie0_c_out", 32'(c_out), 4);
    chk("tie0_no_ack1", 32'(ack1), 0);
    @(posedge clk); #1 req0 = 1'b0;
    wait_ack(1, "tie1");
    chk("tie1_c_out", 32'(c_out), 7);
    chk("tie1_no_ack0", 32'(ack0), 0);
    chk("tie1_grant", 32'(grant), 1);
    @(posedge clk); #1 req1 = 1'b0;
    repeat (3) @(posedge clk);

    // Fairness: both clients keep re-requesting
    do_reset();
    @(posedge clk); #1
    req0 = 1'b1; req1 = 1'b1; ab0 = {8'd100, 8'd75}; ab1 = {8'd64, 8'd48};
    for (int k = 0; k < 4; k++) begin
      wait_any("fair");
      chk("fair_grant_seq", 32'(grant), k % 2);
      chk("fair_ack_seq", 32'(ack1), k % 2);
      @(posedge clk); #1
      if (k == 3) begin
        req0 = 1'b0; req1 = 1'b0;
      end else if (ack1) req1 = 1'b0;
      else req0 = 1'b0;
      @(posedge clk); #1
      if (k < 3) begin
        req0 = 1'b1; req1 = 1'b1;
      end
    end
    repeat (3) @(posedge clk);

    // Early drop: one-cycle request pulse
    @(posedge clk); #1 req1 = 1'b1; ab1 = {8'd9, 8'd6};
    @(posedge clk); #1 req1 = 1'b0;
    wait_ack(1, "early");
    chk("early_c_out", 32'(c_out), 3);
    @(posedge clk); #1;
    chk("early_ack_one_cycle", 32'(ack1), 0);
    repeat (3) @(posedge clk);

    // Reset in RELEASE, then core ack held high across release of reset
    @(posedge clk); #1 req0 = 1'b1; ab0 = {8'd20, 8'd15};
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (busy && !core_req && core_ack && !ack0 && !ack1) break;
      n++;
    end
    chk("rel_reached", 32'(n < 40), 1);
    core_mode = 2;
    reset = 1'b1;
    #1;
    chk_all_zero("midreset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stale_ack_blocks_req", 32'(core_req), 0);
    end
    core_mode = 0;
    n = 0;
    while (n < 10 && !core_req) begin
      @(negedge clk);
      n++;
    end
    chk("reissue_after_ack_low", 32'(core_req), 1);
    wait_ack(0, "reissue");
    chk("reissue_c_out", 32'(c_out), 5);
    @(posedge clk); #1 req0 = 1'b0;
    repeat (3) @(posedge clk);

    // Stuck core
    core_mode = 1;
    @(posedge clk); #1 req1 = 1'b1; ab1 = {8'd0, 8'd0};
    repeat (12) @(negedge clk);
    chk("stuck_core_req", 32'(core_req), 1);
    chk("stuck_busy", 32'(busy), 1);
    chk("stuck_no_ack", 32'({ack1, ack0}), 0);
    chk("stuck_grant", 32'(grant), 1);
    do_reset();
    core_mode = 0;
    repeat (2) @(posedge clk);

    // Random 4-phase clients, zero operands included
    raise_en = 1'b1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic [2*OPW-1:0] v;
      @(posedge clk); #1;
      if (cyc >= 450) raise_en = 1'b0;
      v = {(($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom)), 8'($urandom)};
      if (req0 && ack0) req0 = 1'b0;
      else if (!req0 && !ack0 && raise_en && $urandom_range(0, 2) == 0) begin
        ab0 = v; req0 = 1'b1;
      end
      v = {8'($urandom), (($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom))};
      if (req1 && ack1) req1 = 1'b0;
      else if (!req1 && !ack1 && raise_en && $urandom_range(0, 2) == 0) begin
        ab1 = v; req1 = 1'b1;
      end
    end
    @(negedge clk);
    chk("random_drained", 32'({req1, req0, busy}), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
